// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I control FSM and its datapath.
// The master side is the FSM; the slave side is the datapath that consumes the strobes.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             alu_bcond;
  logic             halt_req;
  logic             pc_write;
  logic             pc_write_not_cond;
  logic             pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             is_ecall;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, alu_bcond, halt_req,
    output pc_write, pc_write_not_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
           is_ecall, halted, retired
  );

  modport slave (
    output opcode, alu_bcond, halt_req,
    input  pc_write, pc_write_not_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
           is_ecall, halted, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB per opcode,
// drives PC write controls and datapath selects, detects ECALL halt and counts retirements.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t           state, next_state;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IF;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_HALT)
        halted_q <= 1'b1;
      if (next_state == S_IF)
        retired_q <= retired_q + 1'b1;
    end
  end

  // Strobes are all forced low while reset is high, even though the state already reads IF.
  always_comb begin
    next_state            = state;
    bus.pc_write          = 1'b0;
    bus.pc_write_not_cond = 1'b0;
    bus.pc_source         = 1'b0;
    bus.i_or_d            = 1'b0;
    bus.mem_read          = 1'b0;
    bus.mem_write         = 1'b0;
    bus.ir_write          = 1'b0;
    bus.reg_write         = 1'b0;
    bus.wb_sel            = 2'b00;
    bus.alu_src_a         = 2'b00;
    bus.alu_src_b         = 2'b00;
    bus.alu_op            = 2'b00;
    bus.is_ecall          = 1'b0;
    if (!reset) begin
      case (state)
        S_IF: begin
          bus.mem_read = 1'b1;
          bus.ir_write = 1'b1;
          next_state   = S_ID;
        end
        S_ID: begin
          bus.alu_src_b = 2'b01;
          if (bus.opcode == OP_ECALL) begin
            bus.is_ecall = 1'b1;
            next_state   = bus.halt_req ? S_HALT : S_WB;
          end else if (bus.opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI,
                                          OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH}) begin
            next_state = S_EX;
          end else begin
            next_state = S_WB;
          end
        end
        S_EX: begin
          next_state = S_WB;
          case (bus.opcode)
            OP_R: begin
              bus.alu_src_a = 2'b01;
              bus.alu_op    = 2'b10;
            end
            OP_I: begin
              bus.alu_src_a = 2'b01;
              bus.alu_src_b = 2'b10;
              bus.alu_op    = 2'b10;
            end
            OP_LOAD, OP_STORE: begin
              bus.alu_src_a = 2'b01;
              bus.alu_src_b = 2'b10;
              next_state    = S_MEM;
            end
            OP_LUI: begin
              bus.alu_src_a = 2'b10;
              bus.alu_src_b = 2'b10;
            end
            OP_AUIPC, OP_JAL: bus.alu_src_b = 2'b10;
            OP_JALR: begin
              bus.alu_src_a = 2'b01;
              bus.alu_src_b = 2'b10;
            end
            // ALUOut still holds PC+4 from ID, so a failed compare falls through to PC+4.
            OP_BRANCH: begin
              bus.alu_src_a         = 2'b01;
              bus.alu_op            = 2'b01;
              bus.pc_write_not_cond = 1'b1;
              bus.pc_source         = 1'b1;
              next_state            = bus.alu_bcond ? S_BR : S_IF;
            end
            default: next_state = S_IF;
          endcase
        end
        S_BR: begin
          bus.alu_src_b = 2'b10;
          bus.pc_write  = 1'b1;
          next_state    = S_IF;
        end
        S_MEM: begin
          bus.i_or_d = 1'b1;
          next_state = S_IF;
          if (bus.opcode == OP_LOAD) begin
            bus.mem_read = 1'b1;
            next_state   = S_WB;
          end else if (bus.opcode == OP_STORE) begin
            bus.mem_write = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.pc_write  = 1'b1;
          end
        end
        S_WB: begin
          bus.pc_write = 1'b1;
          next_state   = S_IF;
          case (bus.opcode)
            OP_LOAD: begin
              bus.reg_write = 1'b1;
              bus.wb_sel    = 2'b01;
              bus.alu_src_b = 2'b01;
            end
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
              bus.reg_write = 1'b1;
              bus.alu_src_b = 2'b01;
            end
            // Jumps write the live PC+4 to rd while the PC takes the target held in ALUOut.
            OP_JAL, OP_JALR: begin
              bus.reg_write = 1'b1;
              bus.wb_sel    = 2'b10;
              bus.alu_src_b = 2'b01;
              bus.pc_source = 1'b1;
            end
            default: bus.pc_source = 1'b1;
          endcase
        end
        S_HALT: next_state = S_HALT;
        default: next_state = S_IF;
      endcase
    end
  end

  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed opcode sequences push per-cycle
// expected control words; an independent monitor pops and compares them.
module tb_multicycle_control_fsm;
  localparam int CW = 3;

  // Control word: {pcw,pcwnc,pcs,iod,mr,mw,irw,rw,wb[1:0],a[1:0],b[1:0],op[1:0],ecall,halted}
  localparam logic [17:0] PCW   = 18'h20000;
  localparam logic [17:0] PCWNC = 18'h10000;
  localparam logic [17:0] PCS   = 18'h08000;
  localparam logic [17:0] IOD   = 18'h04000;
  localparam logic [17:0] MR    = 18'h02000;
  localparam logic [17:0] MW    = 18'h01000;
  localparam logic [17:0] IRW   = 18'h00800;
  localparam logic [17:0] RW    = 18'h00400;
  localparam logic [17:0] WB01  = 18'h00100;
  localparam logic [17:0] WB10  = 18'h00200;
  localparam logic [17:0] A01   = 18'h00040;
  localparam logic [17:0] A10   = 18'h00080;
  localparam logic [17:0] B01   = 18'h00010;
  localparam logic [17:0] B10   = 18'h00020;
  localparam logic [17:0] OP01  = 18'h00004;
  localparam logic [17:0] OP10  = 18'h00008;
  localparam logic [17:0] EC    = 18'h00002;
  localparam logic [17:0] HLT   = 18'h00001;
  localparam logic [17:0] Z     = 18'h00000;

  localparam logic [17:0] C_IF    = MR | IRW;
  localparam logic [17:0] C_ID    = B01;
  localparam logic [17:0] C_IDEC  = B01 | EC;
  localparam logic [17:0] EX_R    = A01 | OP10;
  localparam logic [17:0] EX_I    = A01 | B10 | OP10;
  localparam logic [17:0] EX_LS   = A01 | B10;
  localparam logic [17:0] EX_LUI  = A10 | B10;
  localparam logic [17:0] EX_PCI  = B10;
  localparam logic [17:0] EX_JALR = A01 | B10;
  localparam logic [17:0] EX_BR   = A01 | OP01 | PCWNC | PCS;
  localparam logic [17:0] C_BR    = B10 | PCW;
  localparam logic [17:0] MEM_LD  = IOD | MR;
  localparam logic [17:0] MEM_ST  = IOD | MW | B01 | PCW;
  localparam logic [17:0] WB_LD   = PCW | RW | WB01 | B01;
  localparam logic [17:0] WB_ALU  = PCW | RW | B01;
  localparam logic [17:0] WB_J    = PCW | RW | WB10 | B01 | PCS;
  localparam logic [17:0] WB_EC   = PCW | PCS;

  typedef logic [17:0] seq_t [6];
  typedef struct {
    logic [17:0]   ctl;
    logic [CW-1:0] ret;
    string         name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] act;
  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(CW)) bus_if ();
  multicycle_control_fsm #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  assign act = {bus_if.pc_write, bus_if.pc_write_not_cond, bus_if.pc_source, bus_if.i_or_d,
                bus_if.mem_read, bus_if.mem_write, bus_if.ir_write, bus_if.reg_write,
                bus_if.wb_sel, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
                bus_if.is_ecall, bus_if.halted};

  // Monitor: samples mid-cycle, and also right after an asynchronous reset assertion.
  initial forever begin
    @(negedge clk or posedge reset);
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (act !== cur.ctl) begin
        errors++;
        $display("FAIL %s ctl got %05h want %05h", cur.name, act, cur.ctl);
      end
      checks++;
      if (bus_if.retired !== cur.ret) begin
        errors++;
        $display("FAIL %s retired got %0d want %0d", cur.name, bus_if.retired, cur.ret);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [17:0] c, input string nm);
    exp_t e;
    e.ctl  = c;
    e.ret  = exp_ret[CW-1:0];
    e.name = nm;
    sb.push_back(e);
  endtask

  // Called at the start of an IF cycle; leaves the bench at the start of the next IF cycle
  // when the instruction retires.
  task automatic run(input logic [6:0] op, input logic bc, input logic hr, input string nm,
                     input seq_t seq, input int n, input bit retires);
    bus_if.opcode    = op;
    bus_if.alu_bcond = bc;
    bus_if.halt_req  = hr;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      push(seq[i], $sformatf("%s_c%0d", nm, i));
    end
    if (retires) begin
      step();
      exp_ret++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus_if.opcode    = 7'b0;
    bus_if.alu_bcond = 1'b0;
    bus_if.halt_req  = 1'b0;
    step();
    step();
    push(Z, "reset_hold");
    step();
    reset = 1'b0;

    run(7'b0110011, 1'b0, 1'b0, "r_type", '{C_IF, C_ID, EX_R,   WB_ALU, Z, Z}, 4, 1'b1);
    run(7'b0000011, 1'b0, 1'b0, "load",   '{C_IF, C_ID, EX_LS,  MEM_LD, WB_LD, Z}, 5, 1'b1);
    run(7'b1100011, 1'b0, 1'b0, "br_nt",  '{C_IF, C_ID, EX_BR,  Z, Z, Z}, 3, 1'b1);
    run(7'b1100011, 1'b1, 1'b0, "br_tk",  '{C_IF, C_ID, EX_BR,  C_BR, Z, Z}, 4, 1'b1);
    run(7'b0010011, 1'b0, 1'b0, "i_arith",'{C_IF, C_ID, EX_I,   WB_ALU, Z, Z}, 4, 1'b1);
    run(7'b0110111, 1'b0, 1'b0, "lui",    '{C_IF, C_ID, EX_LUI, WB_ALU, Z, Z}, 4, 1'b1);
    run(7'b0010111, 1'b0, 1'b0, "auipc",  '{C_IF, C_ID, EX_PCI, WB_ALU, Z, Z}, 4, 1'b1);
    run(7'b1101111, 1'b0, 1'b0, "jal",    '{C_IF, C_ID, EX_PCI, WB_J,   Z, Z}, 4, 1'b1);
    run(7'b1100111, 1'b0, 1'b0, "jalr",   '{C_IF, C_ID, EX_JALR,WB_J,   Z, Z}, 4, 1'b1);
    run(7'b0100011, 1'b0, 1'b0, "store",  '{C_IF, C_ID, EX_LS,  MEM_ST, Z, Z}, 4, 1'b1);
    run(7'b0000000, 1'b0, 1'b0, "unknown",'{C_IF, C_ID, WB_EC,  Z, Z, Z}, 3, 1'b1);
    run(7'b1110011, 1'b0, 1'b0, "ecall",  '{C_IF, C_IDEC, WB_EC, Z, Z, Z}, 3, 1'b1);

    run(7'b1110011, 1'b0, 1'b1, "ecall_halt", '{C_IF, C_IDEC, HLT, Z, Z, Z}, 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      push(HLT, $sformatf("halt_hold%0d", i));
    end

    step();
    reset   = 1'b1;
    exp_ret = 0;
    push(Z, "halt_reset");
    step();
    reset = 1'b0;
    bus_if.halt_req = 1'b0;
    run(7'b0110011, 1'b0, 1'b0, "post_halt_r", '{C_IF, C_ID, EX_R, WB_ALU, Z, Z}, 4, 1'b1);

    // Store aborted by a reset asserted in the middle of its MEM cycle.
    run(7'b0100011, 1'b0, 1'b0, "st_abort", '{C_IF, C_ID, EX_LS, MEM_ST, Z, Z}, 4, 1'b0);
    #6;
    exp_ret = 0;
    push(Z, "st_reset_async");
    reset = 1'b1;
    step();
    push(Z, "st_reset_hold");
    step();
    reset = 1'b0;
    run(7'b0110011, 1'b0, 1'b0, "post_rst_r", '{C_IF, C_ID, EX_R, WB_ALU, Z, Z}, 4, 1'b1);
    push(C_IF, "final_if");

    for (int i = 0; i < 5 && sb.size() > 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control FSM for the multi-cycle RV32I core; drives the PC register's write controls and the datapath enables and selects.
- Sequences each instruction through IF/ID/EX/MEM/WB as required by its opcode.
- Consumes the ALU branch condition and asserts the PC conditional-write strobe with a matching next-PC select.
- Detects ECALL halt and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- opcode  input  7  IR[6:0], stable from ID onward
- alu_bcond  input  1  branch comparison result (valid in EX of branch)
- halt_req  input  1  x17==10 at ECALL decode
- pc_write  output  1  unconditional PC write
- pc_write_not_cond  output  1  PC write when alu_bcond==0
- pc_source  output  1  next_pc select: 0 = live ALU result, 1 = ALUOut register
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read
- mem_write  output  1  memory write
- ir_write  output  1  latch IR
- reg_write  output  1  register file write
- wb_sel  output  2  rd data: 00 ALUOut, 01 MDR, 10 live ALU result
- alu_src_a  output  2  00 PC, 01 rs1 reg A, 10 zero
- alu_src_b  output  2  00 reg B, 01 constant 4, 10 immediate
- alu_op  output  2  00 ADD, 01 BRANCH compare, 10 FUNCT decode
- is_ecall  output  1  ECALL decoded
- halted  output  1  sticky halt
- retired  output  CNT_W  instructions retired

Behaviour:
- State register: 3 bits; IF=0, ID=1, EX=2, MEM=3, WB=4, BR=5, HALT=6.
- Async reset: state=IF, halted=0, retired=0.
- Outputs are Moore on state, qualified by opcode in ID and later states. All unlisted outputs are 0 in every state.
- IF:
  - mem_read=1, i_or_d=0, ir_write=1 → ID.
- ID:
  - a=00, b=01, op=ADD; ALUOut latches PC+4.
  - ECALL (1110011): is_ecall=1.
    - halt_req=1 → HALT.
    - halt_req=0 → WB.
  - Unknown opcode → WB.
  - All other opcodes → EX.
- EX:
  - R (0110011): a=01, b=00, op=FUNCT → WB.
  - I-arith (0010011): a=01, b=10, op=FUNCT → WB.
  - LOAD/STORE: a=01, b=10, ADD → MEM.
  - LUI: a=10, b=10, ADD → WB.
  - AUIPC: a=00, b=10, ADD → WB.
  - JAL: a=00, b=10, ADD → WB.
  - JALR: a=01, b=10, ADD → WB.
  - BRANCH: a=01, b=00, op=BRANCH, pc_write_not_cond=1, pc_source=1 (ALUOut=PC+4).
    - alu_bcond=0 → IF; the PC register takes PC+4.
    - alu_bcond=1 → BR.
- BR:
  - a=00, b=10, ADD, pc_source=0, pc_write=1 → IF.
- MEM:
  - i_or_d=1 in both cases.
  - LOAD: mem_read=1 → WB.
  - STORE: mem_write=1, a=00, b=01, ADD, pc_source=0, pc_write=1 → IF.
- WB:
  - pc_write=1 in all cases.
  - LOAD: reg_write=1, wb_sel=01; ALU computes PC+4, pc_source=0.
  - R/I/LUI/AUIPC: reg_write=1, wb_sel=00; ALU computes PC+4, pc_source=0.
  - JAL/JALR: reg_write=1, wb_sel=10; ALU computes PC+4; pc_source=1 (ALUOut=target).
  - ECALL / unknown: reg_write=0; pc_source=1 (ALUOut=PC+4 from ID).
  - Next state: IF.
- HALT:
  - halted=1 and sticky until reset; all strobes 0; stays in HALT.
- retired:
  - Increments by 1 on each transition into IF; wraps modulo 2^CNT_W.
  - Does not count the ECALL that halts.
- Reset mid-instruction: aborts immediately to IF; no strobe is asserted while reset is high.
- Cycle counts:
  - R, I, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Branch not taken: 3 cycles; taken: 4 cycles.
  - ECALL (non-halting): 3 cycles.

Test Plan:
- Reset released, opcode=0110011 → state sequence IF,ID,EX,WB. In WB: reg_write=1, wb_sel=00, pc_write=1. retired=1 at the next IF.
- opcode=0000011 → 5 cycles. In MEM: mem_read=1, i_or_d=1. In WB: wb_sel=01. retired increments once.
- opcode=1100011, alu_bcond=0 → back at IF after 3 cycles. In EX: pc_write_not_cond=1, pc_source=1. pc_write is never asserted.
- opcode=1100011, alu_bcond=1 → BR state follows EX. In BR: pc_write=1, pc_source=0, alu_src_b=10. Total 4 cycles.
- opcode=1110011, halt_req=1 → In ID: is_ecall=1. Next cycle halted=1 and held for 10+ cycles with all strobes 0; retired unchanged. Reset returns to IF with halted=0.
- Store in progress; reset asserted asynchronously during MEM → mem_write drops immediately, state=IF, retired=0. After release, IF strobes (mem_read, ir_write) appear on the next cycle.
